// File: rtl/router_input_port_pkg.sv
// router_input_port_pkg: shared ring-router flit layout, route-select encoding and hop-field helper
package router_input_port_pkg;
  localparam int DATA_W  = 64;
  localparam int VC_BIT  = 63;
  localparam int HOP_MSB = 55;
  localparam int HOP_LSB = 48;
  localparam int HOP_W   = HOP_MSB - HOP_LSB + 1;
  localparam int CNT_W   = 16;
  localparam logic VC1   = 1'b0;
  localparam logic VC2   = 1'b1;
  typedef enum logic [1:0] {
    ROUTE_NONE = 2'd0,
    ROUTE_FWD  = 2'd1,
    ROUTE_PE   = 2'd2
  } route_e;
  function automatic logic [HOP_W-1:0] hop_of(input logic [DATA_W-1:0] flit);
    return flit[HOP_MSB:HOP_LSB];
  endfunction
endpackage

// File: rtl/router_input_port_vc_flit_slot.sv
// vc_flit_slot: one-entry VC flit buffer with route decode, hop decrement, grant release, rx counter and sticky errors
//   wr: flit offered to this VC; din: flit; gnt_fwd/gnt_pe: arbiter grant pulses
//   full/req_fwd/req_pe/dout: buffer state toward arbiters; cnt: accepted flits; err_ovf/err_gnt: sticky errors
module vc_flit_slot
  import router_input_port_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  input  logic              gnt_fwd,
  input  logic              gnt_pe,
  output logic              full,
  output logic              req_fwd,
  output logic              req_pe,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  cnt,
  output logic              err_ovf,
  output logic              err_gnt
);
  route_e             route_q, route_d;
  logic [DATA_W-1:0]  data_q, data_d, dec;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_ovf_q, err_ovf_d, err_gnt_q, err_gnt_d;
  logic               cap, rel, bad, eject;
  always_ff @(posedge clk) begin
    if (reset) begin
      route_q   <= ROUTE_NONE;
      data_q    <= '0;
      cnt_q     <= '0;
      err_ovf_q <= 1'b0;
      err_gnt_q <= 1'b0;
    end else begin
      route_q   <= route_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      err_ovf_q <= err_ovf_d;
      err_gnt_q <= err_gnt_d;
    end
  end
  // Capture only into a registered-empty slot, so release and refill never share a cycle.
  always_comb begin
    dec                   = din;
    dec[HOP_MSB:HOP_LSB]  = hop_of(din) - 8'd1;
    eject                 = hop_of(din) == '0;
    cap                   = wr && route_q == ROUTE_NONE;
    rel                   = (gnt_fwd && route_q == ROUTE_FWD) || (gnt_pe && route_q == ROUTE_PE);
    bad                   = (gnt_fwd && route_q != ROUTE_FWD) || (gnt_pe && route_q != ROUTE_PE);
    route_d               = cap ? (eject ? ROUTE_PE : ROUTE_FWD) : rel ? ROUTE_NONE : route_q;
    data_d                = cap ? (eject ? din : dec) : data_q;
    cnt_d                 = cap ? cnt_q + 1'b1 : cnt_q;
    err_ovf_d             = err_ovf_q | (wr && route_q != ROUTE_NONE);
    err_gnt_d             = err_gnt_q | bad;
  end
  assign full    = route_q != ROUTE_NONE;
  assign req_fwd = route_q == ROUTE_FWD;
  assign req_pe  = route_q == ROUTE_PE;
  assign dout    = data_q;
  assign cnt     = cnt_q;
  assign err_ovf = err_ovf_q;
  assign err_gnt = err_gnt_q;
endmodule

// File: rtl/router_input_port.sv
// router_input_port: ring-router input port steering upstream flits into per-VC one-entry slots for output arbitration
//   si/di: upstream flit; ri_vcX: VC can accept; vcX_req_fwd/pe + vcX_dout: arbiter requests;
//   vcX_gnt_fwd/pe: grant pulses; rx_cnt_vcX: accepted counts; err_overflow/err_grant: sticky errors
module router_input_port
  import router_input_port_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              si,
  input  logic [DATA_W-1:0] di,
  output logic              ri_vc1,
  output logic              ri_vc2,
  output logic              vc1_req_fwd,
  output logic              vc1_req_pe,
  output logic              vc2_req_fwd,
  output logic              vc2_req_pe,
  output logic [DATA_W-1:0] vc1_dout,
  output logic [DATA_W-1:0] vc2_dout,
  input  logic              vc1_gnt_fwd,
  input  logic              vc1_gnt_pe,
  input  logic              vc2_gnt_fwd,
  input  logic              vc2_gnt_pe,
  output logic [CNT_W-1:0]  rx_cnt_vc1,
  output logic [CNT_W-1:0]  rx_cnt_vc2,
  output logic              err_overflow,
  output logic              err_grant
);
  logic full1, full2, ovf1, ovf2, gerr1, gerr2;
  vc_flit_slot u_vc1 (
    .clk(clk), .reset(reset), .wr(si && di[VC_BIT] == VC1), .din(di),
    .gnt_fwd(vc1_gnt_fwd), .gnt_pe(vc1_gnt_pe), .full(full1),
    .req_fwd(vc1_req_fwd), .req_pe(vc1_req_pe), .dout(vc1_dout),
    .cnt(rx_cnt_vc1), .err_ovf(ovf1), .err_gnt(gerr1)
  );
  vc_flit_slot u_vc2 (
    .clk(clk), .reset(reset), .wr(si && di[VC_BIT] == VC2), .din(di),
    .gnt_fwd(vc2_gnt_fwd), .gnt_pe(vc2_gnt_pe), .full(full2),
    .req_fwd(vc2_req_fwd), .req_pe(vc2_req_pe), .dout(vc2_dout),
    .cnt(rx_cnt_vc2), .err_ovf(ovf2), .err_gnt(gerr2)
  );
  assign ri_vc1       = ~full1;
  assign ri_vc2       = ~full2;
  assign err_overflow = ovf1 | ovf2;
  assign err_grant    = gerr1 | gerr2;
endmodule

// File: tb/tb_router_input_port.sv
// tb_router_input_port: directed self-checking bench for router_input_port with a small two-VC scoreboard
module tb_router_input_port;
  logic        clk = 1'b0, reset = 1'b1, si = 1'b0;
  logic [63:0] di = '0;
  logic        ri_vc1, ri_vc2, vc1_req_fwd, vc1_req_pe, vc2_req_fwd, vc2_req_pe;
  logic [63:0] vc1_dout, vc2_dout;
  logic        vc1_gnt_fwd = 1'b0, vc1_gnt_pe = 1'b0, vc2_gnt_fwd = 1'b0, vc2_gnt_pe = 1'b0;
  logic [15:0] rx_cnt_vc1, rx_cnt_vc2;
  logic        err_overflow, err_grant;
  int          tests = 0, fails = 0;
  router_input_port dut (
    .clk(clk), .reset(reset), .si(si), .di(di),
    .ri_vc1(ri_vc1), .ri_vc2(ri_vc2),
    .vc1_req_fwd(vc1_req_fwd), .vc1_req_pe(vc1_req_pe),
    .vc2_req_fwd(vc2_req_fwd), .vc2_req_pe(vc2_req_pe),
    .vc1_dout(vc1_dout), .vc2_dout(vc2_dout),
    .vc1_gnt_fwd(vc1_gnt_fwd), .vc1_gnt_pe(vc1_gnt_pe),
    .vc2_gnt_fwd(vc2_gnt_fwd), .vc2_gnt_pe(vc2_gnt_pe),
    .rx_cnt_vc1(rx_cnt_vc1), .rx_cnt_vc2(rx_cnt_vc2),
    .err_overflow(err_overflow), .err_grant(err_grant)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] stored(input logic [63:0] f);
    logic [63:0] r;
    r = f;
    if (f[55:48] != 8'd0) r[55:48] = f[55:48] - 8'd1;
    return r;
  endfunction
  logic [63:0] exp_data [2];
  logic        exp_pe   [2];
  logic        pending  [2];
  logic [63:0] flit;
  logic [7:0]  hop;
  initial begin
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_ri_vc1", ri_vc1, 1);
    check("rst_ri_vc2", ri_vc2, 1);
    check("rst_reqs", {vc1_req_fwd, vc1_req_pe, vc2_req_fwd, vc2_req_pe}, 0);
    check("rst_cnt", {rx_cnt_vc1, rx_cnt_vc2}, 0);
    check("rst_errs", {err_overflow, err_grant}, 0);
    check("rst_dout1", vc1_dout, 0);
    si = 1'b1; di = {1'b0, 7'h0, 8'h03, 48'hABCD};
    tick();
    si = 1'b0;
    check("fwd_req_fwd", vc1_req_fwd, 1);
    check("fwd_req_pe", vc1_req_pe, 0);
    check("fwd_dout", vc1_dout, {1'b0, 7'h0, 8'h02, 48'hABCD});
    check("fwd_ri_vc1", ri_vc1, 0);
    check("fwd_ri_vc2", ri_vc2, 1);
    check("fwd_cnt1", rx_cnt_vc1, 1);
    vc1_gnt_fwd = 1'b1;
    tick();
    vc1_gnt_fwd = 1'b0;
    check("fwd_rel_req", vc1_req_fwd, 0);
    check("fwd_rel_ri", ri_vc1, 1);
    check("fwd_rel_errg", err_grant, 0);
    si = 1'b1; di = {1'b1, 7'h11, 8'h00, 48'h1234_5678_9ABC};
    tick();
    si = 1'b0;
    check("ej_req_pe", vc2_req_pe, 1);
    check("ej_req_fwd", vc2_req_fwd, 0);
    check("ej_dout", vc2_dout, {1'b1, 7'h11, 8'h00, 48'h1234_5678_9ABC});
    check("ej_cnt2", rx_cnt_vc2, 1);
    check("ej_cnt1", rx_cnt_vc1, 1);
    vc2_gnt_pe = 1'b1;
    tick();
    vc2_gnt_pe = 1'b0;
    check("ej_rel_req", vc2_req_pe, 0);
    check("ej_rel_ri", ri_vc2, 1);
    check("ej_rel_errg", err_grant, 0);
    vc2_gnt_fwd = 1'b1;
    tick();
    vc2_gnt_fwd = 1'b0;
    check("badgnt_errg", err_grant, 1);
    check("badgnt_erro", err_overflow, 0);
    si = 1'b1; di = {1'b0, 7'h05, 8'h05, 48'h1111};
    tick();
    check("ovf_fill_cnt", rx_cnt_vc1, 2);
    di = {1'b0, 7'h06, 8'h09, 48'h2222};
    tick();
    si = 1'b0;
    check("ovf_dout", vc1_dout, {1'b0, 7'h05, 8'h04, 48'h1111});
    check("ovf_err", err_overflow, 1);
    check("ovf_cnt", rx_cnt_vc1, 2);
    check("ovf_req", vc1_req_fwd, 1);
    check("ovf_vc2_ri", ri_vc2, 1);
    vc1_gnt_fwd = 1'b1; si = 1'b1; di = {1'b1, 7'h22, 8'h01, 48'h3333};
    tick();
    vc1_gnt_fwd = 1'b0; si = 1'b0;
    check("cc_ri_vc1", ri_vc1, 1);
    check("cc_ri_vc2", ri_vc2, 0);
    check("cc_vc2_fwd", vc2_req_fwd, 1);
    check("cc_vc2_dout", vc2_dout, {1'b1, 7'h22, 8'h00, 48'h3333});
    check("cc_cnt2", rx_cnt_vc2, 2);
    vc2_gnt_fwd = 1'b1;
    tick();
    vc2_gnt_fwd = 1'b0;
    check("cc_rel_ri2", ri_vc2, 1);
    pending[0] = 1'b0; pending[1] = 1'b0;
    for (int i = 0; i < 100; i++) begin
      hop  = 8'(i % 4);
      flit = {i[0], i[6:0], hop, 48'(i * 3 + 7)};
      check("bb_ri", i[0] ? ri_vc2 : ri_vc1, 1);
      if (pending[!i[0]]) begin
        check("bb_dout", i[0] ? vc1_dout : vc2_dout, exp_data[!i[0]]);
        check("bb_pe", i[0] ? vc1_req_pe : vc2_req_pe, exp_pe[!i[0]]);
        if (i[0]) begin
          vc1_gnt_pe = exp_pe[0]; vc1_gnt_fwd = !exp_pe[0];
        end else begin
          vc2_gnt_pe = exp_pe[1]; vc2_gnt_fwd = !exp_pe[1];
        end
      end
      si = 1'b1; di = flit;
      tick();
      {si, vc1_gnt_fwd, vc1_gnt_pe, vc2_gnt_fwd, vc2_gnt_pe} = '0;
      pending[!i[0]] = 1'b0;
      pending[i[0]]  = 1'b1;
      exp_data[i[0]] = stored(flit);
      exp_pe[i[0]]   = hop == 8'd0;
    end
    check("bb_last_dout", vc2_dout, exp_data[1]);
    vc2_gnt_pe = exp_pe[1]; vc2_gnt_fwd = !exp_pe[1];
    tick();
    {vc2_gnt_fwd, vc2_gnt_pe} = '0;
    check("bb_cnt1", rx_cnt_vc1, 52);
    check("bb_cnt2", rx_cnt_vc2, 52);
    check("bb_empty", {ri_vc1, ri_vc2}, 2'b11);
    si = 1'b1; di = {1'b0, 7'h0, 8'h02, 48'h4444};
    tick();
    di = {1'b1, 7'h0, 8'h00, 48'h5555};
    tick();
    si = 1'b0;
    check("mid_full", {ri_vc1, ri_vc2}, 2'b00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_reqs", {vc1_req_fwd, vc1_req_pe, vc2_req_fwd, vc2_req_pe}, 0);
    check("mid_ri", {ri_vc1, ri_vc2}, 2'b11);
    check("mid_cnt", {rx_cnt_vc1, rx_cnt_vc2}, 0);
    check("mid_errs", {err_overflow, err_grant}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
